// File: rtl/iter_alu_responder.sv
// Responder side of the request/valid ALU handshake: add/sub in one cycle, shift-add multiply and
// restoring divide one bit per cycle. Define ITER_ALU_STATUS_EN to add the status[2:0] flag output.
module iter_alu_responder #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             request,
   input  logic [width-1:0] operandA,
   input  logic [width-1:0] operandB,
   input  logic [1:0]       opcode,
   output logic [width-1:0] result,
   output logic             valid,
   output logic             busy
`ifdef ITER_ALU_STATUS_EN
   ,
   output logic [2:0]       status
`endif
);

   localparam int CW = $clog2(width + 1);
`ifdef ITER_ALU_STATUS_EN
   // Full-width product is needed to detect multiply overflow.
   localparam int AW = 2 * width;
`else
   localparam int AW = width;
`endif

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_RELEASE} state_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    a_q, a_d;
   logic [width-1:0] b_q, b_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [width-1:0] rem_q, rem_d;
   logic [width-1:0] result_q, result_d;

   logic [AW-1:0]    acc_step;
   logic [width:0]   rem_sh;
   logic [width-1:0] rem_sub;
   logic             div_ge;
   logic [width-1:0] quot_nx;

   // One iteration of each datapath; a_q holds the multiplicand for MUL and the
   // dividend-in / quotient-out shift register for DIV.
   always_comb begin
      acc_step = b_q[0] ? acc_q + a_q : acc_q;
      rem_sh   = {rem_q, a_q[width-1]};
      div_ge   = rem_sh >= {1'b0, b_q};
      rem_sub  = rem_sh[width-1:0] - b_q;
      quot_nx  = {a_q[width-2:0], div_ge};
   end

   // NOTE: every *_d gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (request) begin
               op_d  = op_e'(opcode);
               a_d   = AW'(operandA);
               b_d   = operandB;
               acc_d = '0;
               rem_d = '0;
               unique case (op_e'(opcode))
                  OP_ADD: begin
                     result_d = operandA + operandB;
                     state_d  = S_DONE;
                  end
                  OP_SUB: begin
                     result_d = operandA - operandB;
                     state_d  = S_DONE;
                  end
                  default: begin
                     cnt_d   = CW'(width);
                     state_d = S_CALC;
                  end
               endcase
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
               acc_d = acc_step;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else begin
               rem_d = div_ge ? rem_sub : rem_sh[width-1:0];
               a_d   = AW'(quot_nx);
            end
            if (cnt_q == CW'(1)) begin
               result_d = (op_q == OP_MUL) ? acc_step[width-1:0] : quot_nx;
               state_d  = S_DONE;
            end
         end
         S_DONE: state_d = S_RELEASE;
         S_RELEASE: begin
            if (!request) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;
   assign valid  = (state_q == S_DONE);
   assign busy   = (state_q != S_IDLE);

`ifdef ITER_ALU_STATUS_EN
   logic [2:0]     status_q, status_d;
   logic [width:0] add_full;

   // Flags load on the same edge as result: {div_by_zero, carry/borrow/overflow, zero}.
   always_comb begin
      add_full = {1'b0, operandA} + {1'b0, operandB};
      status_d = status_q;
      if (state_q == S_IDLE && request) begin
         if (op_e'(opcode) == OP_ADD)
            status_d = {1'b0, add_full[width], add_full[width-1:0] == '0};
         else if (op_e'(opcode) == OP_SUB)
            status_d = {1'b0, operandA < operandB, operandA == operandB};
      end else if (state_q == S_CALC && cnt_q == CW'(1)) begin
         if (op_q == OP_MUL)
            status_d = {1'b0, |acc_step[AW-1:width], acc_step[width-1:0] == '0};
         else
            status_d = {b_q == '0, 1'b0, quot_nx == '0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) status_q <= '0;
      else       status_q <= status_d;
   end

   assign status = status_q;
`endif

endmodule

// File: tb/tb_iter_alu_responder.sv
// Scoreboard bench for iter_alu_responder: driver pushes expected result/latency, negedge monitor
// pops and compares on every valid pulse. Status flags are checked when ITER_ALU_STATUS_EN is set.
module tb_iter_alu_responder;

   localparam int W = 32;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         request = 1'b0;
   logic [W-1:0] operandA = '0;
   logic [W-1:0] operandB = '0;
   logic [1:0]   opcode = '0;
   logic [W-1:0] result;
   logic         valid;
   logic         busy;
`ifdef ITER_ALU_STATUS_EN
   logic [2:0]   status;
`endif

   iter_alu_responder #(.width(W)) dut (
`ifdef ITER_ALU_STATUS_EN
      .status  (status),
`endif
      .clk     (clk),
      .reset   (reset),
      .request (request),
      .operandA(operandA),
      .operandB(operandB),
      .opcode  (opcode),
      .result  (result),
      .valid   (valid),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   st;
      int           edge_n;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
   endtask

   // Monitor: every valid pulse must match the head of the scoreboard.
   logic prev_valid = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (valid) begin
            check("valid_single_cycle", prev_valid, 0);
            if (sb.size() == 0) begin
               check("spurious_valid", valid, 0);
            end else begin
               mon_e = sb.pop_front();
               check("result", result, mon_e.res);
               check("latency_edge", cyc + 1, mon_e.edge_n);
`ifdef ITER_ALU_STATUS_EN
               check("status", status, mon_e.st);
`endif
            end
         end
         prev_valid = valid;
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] exp_res, input logic [2:0] exp_st, input int hold);
      int   lat = op[1] ? W + 1 : 1;
      int   n = 0;
      exp_t e;
      @(negedge clk);
      request  = 1'b1;
      operandA = a;
      operandB = b;
      opcode   = op;
      @(posedge clk);
      #1;
      e.res    = exp_res;
      e.st     = exp_st;
      e.edge_n = cyc + lat;
      sb.push_back(e);
      check("busy_at_capture", busy, 1);
      // Operand changes after capture must not disturb the computation.
      operandA = ~a;
      operandB = ~b;
      opcode   = ~op;
      while (!valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("valid_seen", valid, 1);
      @(posedge clk);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      check("busy_in_release", busy, 1);
      request = 1'b0;
      @(posedge clk);
      #1;
      check("busy_cleared", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      #2;
      check("reset_result", result, 0);
      check("reset_valid", valid, 0);
      check("reset_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;

      do_op(32'hFFFF_FFFF, 32'd1,       ADD, 32'h0000_0000, 3'b011, 0);
      do_op(32'd5,         32'd7,       SUB, 32'hFFFF_FFFE, 3'b010, 0);
      do_op(32'd7,         32'd5,       SUB, 32'd2,         3'b000, 0);
      do_op(32'h0001_0000, 32'h0001_0001, MUL, 32'h0001_0000, 3'b010, 0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL, 32'd1,       3'b010, 0);
      do_op(32'd12,        32'd11,      MUL, 32'd132,       3'b000, 0);
      do_op(32'd100,       32'd7,       DIV, 32'd14,        3'b000, 0);
      do_op(32'd9,         32'd0,       DIV, 32'hFFFF_FFFF, 3'b100, 0);
      do_op(32'hFFFF_FFFF, 32'd1,       DIV, 32'hFFFF_FFFF, 3'b000, 0);
      do_op(32'd3,         32'd10,      DIV, 32'd0,         3'b001, 0);
      // Initiator holds request 5 cycles past valid: no second capture.
      do_op(32'd6,         32'd7,       ADD, 32'd13,        3'b000, 5);
      do_op(32'd2,         32'd3,       ADD, 32'd5,         3'b000, 0);

      // Abort a multiply with reset; it must never report completion.
      @(negedge clk);
      request  = 1'b1;
      operandA = 32'd3;
      operandB = 32'd5;
      opcode   = MUL;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_result", result, 0);
      check("abort_valid", valid, 0);
      check("abort_busy", busy, 0);
      request = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_idle", busy, 0);

      do_op(32'd1,         32'd1,       ADD, 32'd2,         3'b000, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
